// File: rtl/ila_capture_controller.sv
// ila_capture_controller
// Sequences the write port of an external circular sample RAM through
// pre-trigger fill, armed wait, post-trigger capture and done, and reports
// where the captured window lives so readout can unload it in order.
//
// State table:
//   state   | meaning
//   S_IDLE  | no capture in progress, no writes
//   S_FILL  | pre-trigger fill, one write per cycle, trigger ignored
//   S_ARMED | circular write every cycle, waiting for trigger
//   S_POST  | post-trigger capture, trigger ignored
//   S_DONE  | writes stopped, trig_addr/start_addr/done held
//
// Ports:
//   clock_i, reset_i         clock, synchronous active-high reset
//   arm_i, abort_i           start pulse (IDLE/DONE only), forced return to IDLE
//   trigger_i                one-cycle trigger aligned with probe_data_i
//   pre_count_i/post_count_i window configuration, latched on accepted arm
//   probe_data_i             sample bus
//   wr_en_o/wr_addr_o/wr_data_o  RAM write port
//   busy_o/armed_o/done_o    status decoded from the state register
//   trig_addr_o/start_addr_o location of trigger sample and window start
module ila_capture_controller #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic                  trigger_i,
    input  logic [ADDR_WIDTH-1:0] pre_count_i,
    input  logic [ADDR_WIDTH-1:0] post_count_i,
    input  logic [DATA_WIDTH-1:0] probe_data_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  armed_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] trig_addr_o,
    output logic [ADDR_WIDTH-1:0] start_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] pre_q, pre_d;
    logic [ADDR_WIDTH-1:0] post_q, post_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;

    // State and datapath registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            pre_q        <= pre_d;
            post_q       <= post_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        pre_d        = pre_q;
        post_d       = post_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;

        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_i) begin
                        pre_d   = pre_count_i;
                        post_d  = post_count_i;
                        addr_d  = '0;
                        cnt_d   = '0;
                        state_d = (pre_count_i != '0) ? S_FILL : S_ARMED;
                    end
                end
                S_FILL: begin
                    addr_d = addr_q + ONE;
                    cnt_d  = cnt_q + ONE;
                    if (cnt_q == pre_q - ONE) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    addr_d = addr_q + ONE;
                    if (trigger_i) begin
                        trig_addr_d  = addr_q;
                        // Window start wraps naturally in ADDR_WIDTH bits.
                        start_addr_d = addr_q - pre_q;
                        cnt_d        = '0;
                        state_d      = (post_q == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    addr_d = addr_q + ONE;
                    cnt_d  = cnt_q + ONE;
                    if (cnt_q == post_q - ONE) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from registers only
    always_comb begin
        busy_o  = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
        armed_o = (state_q == S_ARMED);
        done_o  = (state_q == S_DONE);
        wr_en_o = busy_o;
    end

    assign wr_addr_o    = addr_q;
    assign wr_data_o    = probe_data_i;
    assign trig_addr_o  = trig_addr_q;
    assign start_addr_o = start_addr_q;

endmodule

// File: tb/tb_ila_capture_controller.sv
// Bench for ila_capture_controller: a timeline model (arm cycle, trigger
// cycle, window sizes) predicts every output each cycle; directed scenarios
// add literal expectations, then randomized traffic runs against the model.
module tb_ila_capture_controller;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset, arm, abort, trigger;
    logic [AW-1:0] pre_v, post_v;
    logic [DW-1:0] probe;
    logic          wr_en, busy, armed, done;
    logic [AW-1:0] wr_addr, trig_addr, start_addr;
    logic [DW-1:0] wr_data;

    ila_capture_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .arm_i        (arm),
        .abort_i      (abort),
        .trigger_i    (trigger),
        .pre_count_i  (pre_v),
        .post_count_i (post_v),
        .probe_data_i (probe),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .busy_o       (busy),
        .armed_o      (armed),
        .done_o       (done),
        .trig_addr_o  (trig_addr),
        .start_addr_o (start_addr)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 0;
    logic [DW-1:0] ram [DEPTH];

    // Timeline model: a session starts the cycle after an accepted arm.
    bit m_sess = 0;
    int m_arm_c, m_trig_c, m_pre, m_post, m_ta = 0, m_sa = 0;
    int e_k;
    bit e_busy, e_armed, e_done;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_expect();
        e_busy = 0; e_armed = 0; e_done = 0; e_k = 0;
        if (m_sess) begin
            e_k = cyc - m_arm_c - 1;
            if (m_trig_c < 0) begin
                e_busy  = 1;
                e_armed = (e_k >= m_pre);
            end else begin
                e_busy = (cyc <= m_trig_c + m_post);
                e_done = (cyc > m_trig_c + m_post);
            end
        end
    endtask

    // Drive inputs for the current cycle, then compare at the falling edge.
    task automatic step(input bit a, input bit ab, input bit t, input bit r);
        arm = a; abort = ab; trigger = t; reset = r; probe = DW'(cyc);
        @(negedge clock);
        model_expect();
        if (chk_en) begin
            chk("wr_en", int'(wr_en), int'(e_busy));
            chk("busy", int'(busy), int'(e_busy));
            chk("armed", int'(armed), int'(e_armed));
            chk("done", int'(done), int'(e_done));
            chk("trig_addr", int'(trig_addr), m_ta);
            chk("start_addr", int'(start_addr), m_sa);
            if (e_busy) begin
                chk("wr_addr", int'(wr_addr), e_k % DEPTH);
                chk("wr_data", int'(wr_data), int'(probe));
            end
        end
        if (wr_en) ram[wr_addr] = wr_data;
    endtask

    task automatic adv();
        @(posedge clock);
        if (reset) begin
            m_sess = 0; m_ta = 0; m_sa = 0;
        end else if (abort) begin
            m_sess = 0;
        end else if (arm && (!m_sess || e_done)) begin
            m_sess = 1; m_arm_c = cyc; m_trig_c = -1;
            m_pre = int'(pre_v); m_post = int'(post_v);
        end else if (m_sess && m_trig_c < 0 && e_armed && trigger) begin
            m_trig_c = cyc;
            m_ta = e_k % DEPTH;
            m_sa = (((e_k - m_pre) % DEPTH) + DEPTH) % DEPTH;
        end
        cyc++;
        #1;
    endtask

    task automatic go_idle();
        step(0, 1, 0, 0); adv();
    endtask

    initial begin
        arm = 0; abort = 0; trigger = 0; reset = 1; pre_v = '0; post_v = '0; probe = '0;
        #1;
        step(0, 0, 0, 1); adv();
        step(0, 0, 0, 1); adv();
        chk_en = 1;
        step(0, 0, 0, 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_trig", int'(trig_addr), 0);
        adv();

        // Basic capture: pre=3 post=4, trigger at 10
        pre_v = 3; post_v = 4;
        begin
            int b;
            b = cyc;
            for (int r = 0; r <= 16; r++) begin
                step(r == 0, 0, r == 10, 0);
                if (r == 1)  chk("basic_first_wr", int'(wr_en) * 100 + int'(wr_addr), 100);
                if (r == 3)  chk("basic_armed_r3", int'(armed), 0);
                if (r == 4)  chk("basic_armed_r4", int'(armed), 1);
                if (r == 10) chk("basic_armed_r10", int'(armed), 1);
                if (r == 11) chk("basic_trig", int'(trig_addr), 9);
                if (r == 11) chk("basic_start", int'(start_addr), 6);
                if (r == 14) chk("basic_last_wr", int'(wr_en) * 100 + int'(wr_addr), 113);
                if (r == 14) chk("basic_done_r14", int'(done), 0);
                if (r == 15) chk("basic_done_r15", int'(done) * 10 + int'(wr_en), 10);
                adv();
            end
            for (int i = 0; i < 8; i++) chk("basic_ram", int'(ram[6 + i]), (b + 7 + i) % 256);
        end

        // Trigger during FILL ignored: pre=5
        go_idle();
        pre_v = 5; post_v = 2;
        for (int r = 0; r <= 12; r++) begin
            step(r == 0, 0, (r == 3) || (r == 8), 0);
            if (r == 4) chk("fill_trig_ignored", int'(busy) * 10 + int'(armed), 10);
            if (r == 5) chk("fill_armed_r5", int'(armed), 0);
            if (r == 6) chk("fill_armed_r6", int'(armed), 1);
            if (r == 9) chk("fill_trig_addr", int'(trig_addr), 7);
            adv();
        end

        // Wrap-around: pre=10 post=2, trigger at 30
        go_idle();
        pre_v = 10; post_v = 2;
        for (int r = 0; r <= 34; r++) begin
            step(r == 0, 0, r == 30, 0);
            if (r == 31) chk("wrap_trig", int'(trig_addr), 13);
            if (r == 31) chk("wrap_start", int'(start_addr), 3);
            if (r == 31) chk("wrap_addr31", int'(wr_addr), 14);
            if (r == 32) chk("wrap_addr32", int'(wr_addr), 15);
            if (r == 33) chk("wrap_done", int'(done), 1);
            adv();
        end

        // Zero window
        go_idle();
        pre_v = 0; post_v = 0;
        for (int r = 0; r <= 4; r++) begin
            step(r == 0, 0, r == 2, 0);
            if (r == 1) chk("zero_armed", int'(armed), 1);
            if (r == 2) chk("zero_wr_addr", int'(wr_addr), 1);
            if (r == 3) chk("zero_done", int'(done), 1);
            if (r == 3) chk("zero_trig", int'(trig_addr) * 16 + int'(start_addr), 17);
            adv();
        end

        // Abort during POST, then abort+arm together
        go_idle();
        pre_v = 1; post_v = 5;
        for (int r = 0; r <= 8; r++) begin
            step(r == 0 || r == 6, r == 5 || r == 6, r == 3, 0);
            if (r == 5) chk("abort_in_post", int'(busy), 1);
            if (r == 6) chk("abort_next", int'(wr_en) + int'(busy) + int'(done), 0);
            if (r == 7) chk("abort_arm_idle", int'(busy), 0);
            adv();
        end

        // Reset while ARMED
        pre_v = 2; post_v = 3;
        for (int r = 0; r <= 8; r++) begin
            step(r == 0 || r == 5, 0, 0, r == 4);
            if (r == 4) chk("rst_pre_armed", int'(armed), 1);
            if (r == 5) begin
                chk("rst_outs", int'(wr_en) + int'(busy) + int'(armed) + int'(done), 0);
                chk("rst_addrs", int'(wr_addr) + int'(trig_addr) + int'(start_addr), 0);
            end
            if (r == 6) chk("rst_rearm", int'(wr_en) * 100 + int'(wr_addr), 100);
            adv();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            pre_v  = AW'($urandom_range(0, 15));
            post_v = AW'($urandom_range(0, 15));
            step($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 499) == 0);
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
